// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the instruction sequencer.
package ctrl_pkg;

  localparam int OP_W    = 4;
  localparam int PC_W    = 6;
  localparam int COUNT_W = 7;

  localparam logic [OP_W-1:0] HALT_OP_DEF = 4'hF;
  localparam int              MEM_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_ADVANCE   = 3'd2,
    ST_FETCH     = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  function automatic logic is_running(input state_e s);
    return (s != ST_IDLE) && (s != ST_HALT);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - counts FETCH cycles without mem_ready and flags a timeout.
module fetch_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic res,
  input  logic fetch_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] wait_q, wait_d;

  // Fires on the stalled cycle that would bring the count to TIMEOUT.
  assign timeout_o = fetch_i && !mem_ready_i && (wait_q == W'(TIMEOUT - 1));

  always_comb begin
    wait_d = wait_q;
    if (!fetch_i) begin
      wait_d = '0;
    end else if (!mem_ready_i && !timeout_o) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - clear/advance/fetch/execute/writeback sequencer for the PC datapath.
// Optional memory timeout watchdog enabled by CTRL_TIMEOUT_EN.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] LAST_ADDR = 6'd63,
  parameter logic [OP_W-1:0] HALT_OP   = HALT_OP_DEF
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic               mem_ready,
  input  logic [OP_W-1:0]    instr_op,
  output logic               pc_clr,
  output logic               pc_en,
  output logic               ir_load,
  output logic               exec_en,
  output logic               wb_en,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] instr_count
);

  state_e state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic timeout;

`ifdef CTRL_TIMEOUT_EN
  logic error_q, error_d;

  fetch_watchdog #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .res        (res),
    .fetch_i    (state_q == ST_FETCH),
    .mem_ready_i(mem_ready),
    .timeout_o  (timeout)
  );

  always_comb begin
    error_d = error_q;
    if (state_d == ST_CLEAR) begin
      error_d = 1'b0;
    end else if (timeout) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR:   state_d = ST_ADVANCE;
      ST_ADVANCE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_EXECUTE;
        else if (timeout) state_d = ST_HALT;
      end
      ST_EXECUTE: begin
        state_d = (instr_op == HALT_OP) ? ST_HALT : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        state_d = (pc == LAST_ADDR) ? ST_HALT : ST_ADVANCE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_clr  = 1'b0;
    pc_en   = 1'b0;
    ir_load = 1'b0;
    exec_en = 1'b0;
    wb_en   = 1'b0;
    busy    = is_running(state_q);
    done    = 1'b0;
    case (state_q)
      ST_CLEAR:     pc_clr  = 1'b1;
      ST_ADVANCE:   pc_en   = 1'b1;
      ST_FETCH:     ir_load = mem_ready;
      ST_EXECUTE:   exec_en = 1'b1;
      ST_WRITEBACK: wb_en   = 1'b1;
      ST_HALT:      done    = 1'b1;
      default: ;
    endcase
  end

  // Zeroed on entry so the CLEAR cycle already reports an empty run.
  always_comb begin
    count_d = count_q;
    if (state_d == ST_CLEAR) begin
      count_d = '0;
    end else if ((state_q == ST_EXECUTE) && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic [5:0] pc = 6'h00;
  logic       mem_ready;
  logic [3:0] instr_op;
  logic       pc_clr, pc_en, ir_load, exec_en, wb_en, busy, done, error;
  logic [6:0] instr_count;

  logic       halt_en;
  logic [5:0] halt_addr;

  int n_chk = 0;
  int n_err = 0;
  int t = 0;
  int n_pc_en = 0, n_ir = 0, n_exec = 0, n_wb = 0;

  control_sequencer dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .pc         (pc),
    .mem_ready  (mem_ready),
    .instr_op   (instr_op),
    .pc_clr     (pc_clr),
    .pc_en      (pc_en),
    .ir_load    (ir_load),
    .exec_en    (exec_en),
    .wb_en      (wb_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Program counter and instruction memory stand-ins.
  always @(posedge clk) begin
    if (pc_clr)     pc <= 6'h3F;
    else if (pc_en) pc <= pc + 6'd1;
  end

  always_comb instr_op = (halt_en && (pc == halt_addr)) ? 4'hF : 4'h3;

  always @(negedge clk) begin
    if (pc_en   === 1'b1) n_pc_en++;
    if (ir_load === 1'b1) n_ir++;
    if (exec_en === 1'b1) n_exec++;
    if (wb_en   === 1'b1) n_wb++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int k);
    k = 0;
    while ((done !== 1'b1) && (k < limit)) begin
      tick;
      k++;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    int k, t0, t_adv;
    int b_pc, b_ir, b_ex, b_wb;
    logic seen;

    res = 1'b0; start = 1'b0; mem_ready = 1'b0; halt_en = 1'b0; halt_addr = 6'd0;
    repeat (3) tick;
    check("reset_strobes", {pc_clr, pc_en, ir_load, exec_en, wb_en}, 32'h0);
    check("reset_flags", {busy, done, error}, 32'h0);
    check("reset_count", instr_count, 32'd0);
    res = 1'b1;
    tick;
    check("idle_outputs", {pc_clr, pc_en, ir_load, exec_en, wb_en, busy, done, error}, 32'h0);

    // Full 64-instruction run, no wait states
    mem_ready = 1'b1;
    b_pc = n_pc_en; b_ir = n_ir; b_ex = n_exec; b_wb = n_wb;
    pulse_start;
    check("full_clear_pulse", {pc_clr, busy, done}, 32'b110);
    check("full_clear_count", instr_count, 32'd0);
    wait_done(400, k);
    check("full_done", done, 32'd1);
    check("full_cycles", k, 32'd257);
    check("full_pc_en", n_pc_en - b_pc, 32'd64);
    check("full_wb_en", n_wb - b_wb, 32'd64);
    check("full_ir_load", n_ir - b_ir, 32'd64);
    check("full_exec_en", n_exec - b_ex, 32'd64);
    check("full_count", instr_count, 32'd64);
    check("full_busy", busy, 32'd0);
    check("full_last_pc", pc, 32'd63);

    // Halt opcode on the third instruction; start during WRITEBACK is ignored
    halt_en = 1'b1; halt_addr = 6'd2;
    b_ex = n_exec; b_wb = n_wb;
    pulse_start;
    t0 = t;
    check("halt_clear_pulse", pc_clr, 32'd1);
    check("halt_clear_count", instr_count, 32'd0);
    check("halt_clear_done", done, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      if (wb_en === 1'b1) seen = 1'b1;
    end
    check("halt_wb_reached", seen, 32'd1);
    pulse_start;
    check("wb_start_ignored", {pc_clr, pc_en}, 32'b01);
    wait_done(50, k);
    check("halt_done", done, 32'd1);
    check("halt_cycles", t - t0, 32'd12);
    check("halt_exec_en", n_exec - b_ex, 32'd3);
    check("halt_wb_en", n_wb - b_wb, 32'd2);
    check("halt_count", instr_count, 32'd3);
    halt_en = 1'b0;

    // Five FETCH wait cycles stretch the instruction to 9 cycles
    mem_ready = 1'b0;
    pulse_start;
    check("wait_clear_count", {pc_clr, instr_count}, {24'h0, 1'b1, 7'd0});
    tick;
    t_adv = t;
    check("wait_advance", pc_en, 32'd1);
    b_ir = n_ir;
    repeat (5) tick;
    check("wait_no_ir_load", {n_ir - b_ir, busy, error}, {30'd0, 1'b1, 1'b0});
    tick;
    mem_ready = 1'b1;
    #1;
    check("wait_ir_load", ir_load, 32'd1);
    tick;
    check("wait_exec", exec_en, 32'd1);
    tick;
    check("wait_wb", wb_en, 32'd1);
    tick;
    check("wait_next_adv", pc_en, 32'd1);
    check("wait_instr_cycles", t - t_adv, 32'd9);

    // Asynchronous reset during EXECUTE
    tick;
    tick;
    check("pre_reset_exec", exec_en, 32'd1);
    res = 1'b0;
    #1;
    check("async_reset_outputs", {pc_clr, pc_en, ir_load, exec_en, wb_en, busy, done, error}, 32'h0);
    check("async_reset_count", instr_count, 32'd0);
    tick;
    res = 1'b1;
    tick;
    check("post_reset_idle", {busy, done}, 32'b00);
    pulse_start;
    check("post_reset_clear", pc_clr, 32'd1);
    wait_done(400, k);
    check("post_reset_run_done", {done, instr_count}, {24'h0, 1'b1, 7'd64});

`ifdef CTRL_TIMEOUT_EN
    mem_ready = 1'b0;
    b_ir = n_ir;
    pulse_start;
    wait_done(40, k);
    check("timeout_cycles", k, 32'd17);
    check("timeout_flags", {error, done}, 32'b11);
    check("timeout_no_ir_load", n_ir - b_ir, 32'd0);
    pulse_start;
    check("timeout_restart_clear", {pc_clr, error}, 32'b10);
`else
    mem_ready = 1'b0;
    pulse_start;
    repeat (40) tick;
    check("stall_waits", {busy, done, error}, 32'b100);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
